// File: rtl/mips_test_sequencer.sv
// mips_test_sequencer: loads a program image and init data into CPU memory, runs the core, then checks results
module mips_test_sequencer #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 10,
    parameter int PROG_DEPTH = 16,
    parameter int NUM_INIT   = 2,
    parameter int NUM_CHECKS = 4,
    parameter int TIMEOUT    = 4096,
    parameter int CNT_W      = 16
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    output logic [ADDR_W-1:0]                img_addr,
    input  logic [DATA_W-1:0]                img_data,
    input  logic [NUM_INIT*ADDR_W-1:0]       init_addr,
    input  logic [NUM_INIT*DATA_W-1:0]       init_data,
    input  logic [NUM_CHECKS*ADDR_W-1:0]     chk_addr,
    input  logic [NUM_CHECKS*DATA_W-1:0]     chk_exp,
    output logic                             mem_we,
    output logic [ADDR_W-1:0]                mem_addr,
    output logic [DATA_W-1:0]                mem_wdata,
    input  logic [DATA_W-1:0]                mem_rdata,
    output logic                             cpu_run,
    input  logic                             cpu_halted,
    output logic                             busy,
    output logic                             done,
    output logic                             pass,
    output logic                             timeout,
    output logic [$clog2(NUM_CHECKS+1)-1:0]  fail_idx,
    output logic [CNT_W-1:0]                 cycles
);
    localparam int FW = $clog2(NUM_CHECKS + 1);
    localparam int IW = $clog2(PROG_DEPTH + NUM_INIT + NUM_CHECKS + 1);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_INIT, S_RUN, S_RADDR, S_CMP, S_DONE} state_t;

    state_t              r_state;
    logic [IW-1:0]       r_idx;
    logic                r_mem_we;
    logic [ADDR_W-1:0]   r_mem_addr;
    logic [DATA_W-1:0]   r_mem_wdata;
    logic                r_cpu_run;
    logic                r_busy;
    logic                r_done;
    logic                r_pass;
    logic                r_timeout;
    logic [FW-1:0]       r_fail_idx;
    logic [CNT_W-1:0]    r_cycles;

    logic [IW-1:0]       w_idx_nxt;
    logic                w_last_load;
    logic                w_last_init;
    logic                w_last_chk;
    logic [IW-1:0]       w_isel;
    logic [IW-1:0]       w_jsel;
    logic [ADDR_W-1:0]   w_init_a;
    logic [DATA_W-1:0]   w_init_d;
    logic [ADDR_W-1:0]   w_chk_a;
    logic [CNT_W-1:0]    w_cyc;
    logic                w_match;

    assign w_idx_nxt   = r_idx + IW'(1);
    assign w_last_load = r_idx == IW'(PROG_DEPTH - 1);
    assign w_last_init = r_idx == IW'(NUM_INIT - 1);
    assign w_last_chk  = r_idx == IW'(NUM_CHECKS - 1);
    // Next init / check entry to present; clamped so the select never runs past the table
    assign w_isel      = (r_state == S_INIT && !w_last_init) ? w_idx_nxt : '0;
    assign w_jsel      = (r_state == S_CMP && !w_last_chk) ? w_idx_nxt : '0;
    assign w_init_a    = init_addr[w_isel*ADDR_W +: ADDR_W];
    assign w_init_d    = init_data[w_isel*DATA_W +: DATA_W];
    assign w_chk_a     = chk_addr[w_jsel*ADDR_W +: ADDR_W];
    assign w_cyc       = r_cycles + CNT_W'(1);
    assign w_match     = mem_rdata == chk_exp[r_idx*DATA_W +: DATA_W];

    // Image copy passes ROM data straight through to the write port during LOAD
    assign img_addr  = (r_state == S_LOAD) ? ADDR_W'(r_idx) : '0;
    assign mem_wdata = (r_state == S_LOAD) ? img_data : r_mem_wdata;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign cpu_run   = r_cpu_run;
    assign busy      = r_busy;
    assign done      = r_done;
    assign pass      = r_pass;
    assign timeout   = r_timeout;
    assign fail_idx  = r_fail_idx;
    assign cycles    = r_cycles;

    // Sequencer FSM: load, init, run, then compare results one check at a time
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_run   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_pass      <= 1'b0;
            r_timeout   <= 1'b0;
            r_fail_idx  <= FW'(NUM_CHECKS);
            r_cycles    <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state    <= S_LOAD;
                        r_idx      <= '0;
                        r_mem_we   <= 1'b1;
                        r_mem_addr <= '0;
                        r_busy     <= 1'b1;
                        r_done     <= 1'b0;
                        r_pass     <= 1'b0;
                        r_timeout  <= 1'b0;
                        r_fail_idx <= FW'(NUM_CHECKS);
                        r_cycles   <= '0;
                    end
                end
                S_LOAD: begin
                    if (!w_last_load) begin
                        r_idx      <= w_idx_nxt;
                        r_mem_addr <= ADDR_W'(w_idx_nxt);
                    end else if (NUM_INIT == 0) begin
                        r_state    <= S_RUN;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= '0;
                        r_cpu_run  <= 1'b1;
                    end else begin
                        r_state     <= S_INIT;
                        r_idx       <= '0;
                        r_mem_addr  <= w_init_a;
                        r_mem_wdata <= w_init_d;
                    end
                end
                S_INIT: begin
                    if (w_last_init) begin
                        r_state    <= S_RUN;
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= '0;
                        r_cpu_run  <= 1'b1;
                    end else begin
                        r_idx       <= w_idx_nxt;
                        r_mem_addr  <= w_init_a;
                        r_mem_wdata <= w_init_d;
                    end
                end
                S_RUN: begin
                    r_cycles <= w_cyc;
                    if (cpu_halted) begin
                        r_state    <= S_RADDR;
                        r_idx      <= '0;
                        r_mem_addr <= w_chk_a;
                    end else if (w_cyc == CNT_W'(TIMEOUT)) begin
                        r_state   <= S_DONE;
                        r_timeout <= 1'b1;
                        r_cpu_run <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                    end
                end
                S_RADDR: r_state <= S_CMP;
                S_CMP: begin
                    if (!w_match || w_last_chk) begin
                        r_state    <= S_DONE;
                        r_pass     <= w_match;
                        r_fail_idx <= w_match ? FW'(NUM_CHECKS) : FW'(r_idx);
                        r_cpu_run  <= 1'b0;
                        r_busy     <= 1'b0;
                        r_done     <= 1'b1;
                    end else begin
                        r_state    <= S_RADDR;
                        r_idx      <= w_idx_nxt;
                        r_mem_addr <= w_chk_a;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mips_test_sequencer.sv
// tb_mips_test_sequencer: directed vector bench with a memory model and a stand-in core
module tb_mips_test_sequencer;
    logic               clk;
    logic               rst_n;
    logic               start;
    logic [9:0]         img_addr;
    logic [31:0]        img_data;
    logic [19:0]        init_addr;
    logic [63:0]        init_data;
    logic [19:0]        chk_addr;
    logic [63:0]        chk_exp;
    logic               mem_we;
    logic [9:0]         mem_addr;
    logic [31:0]        mem_wdata;
    logic [31:0]        mem_rdata;
    logic               cpu_run;
    logic               cpu_halted;
    logic               busy;
    logic               done;
    logic               pass;
    logic               timeout;
    logic [1:0]         fail_idx;
    logic [15:0]        cycles;

    logic [31:0]        mem [1024];
    logic [31:0]        img [16];
    logic [15:0]        halt_at;
    logic [15:0]        rc;
    int                 nvec;
    int                 nmis;
    int                 bcnt;
    int                 wcnt;
    int                 rcnt;

    typedef struct {
        logic [15:0] halt_at;
        logic [31:0] e0;
        logic [31:0] e1;
        logic        ep;
        logic        eto;
        logic [1:0]  efi;
        logic [15:0] ecyc;
    } vec_t;

    vec_t vt [6];

    mips_test_sequencer #(
        .DATA_W(32), .ADDR_W(10), .PROG_DEPTH(16), .NUM_INIT(2),
        .NUM_CHECKS(2), .TIMEOUT(50), .CNT_W(16)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .img_addr(img_addr), .img_data(img_data),
        .init_addr(init_addr), .init_data(init_data),
        .chk_addr(chk_addr), .chk_exp(chk_exp),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .cpu_run(cpu_run), .cpu_halted(cpu_halted),
        .busy(busy), .done(done), .pass(pass), .timeout(timeout),
        .fail_idx(fail_idx), .cycles(cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Two init writes to the same address: the later (7) must win
    assign init_addr = {10'd200, 10'd200};
    assign init_data = {32'd7, 32'd3};
    assign chk_addr  = {10'd200, 10'd198};
    assign img_data  = (img_addr < 10'd16) ? img[img_addr[3:0]] : 32'd0;
    assign cpu_halted = cpu_run && (halt_at != 16'd0) && (rc + 16'd1 >= halt_at);

    function automatic logic [31:0] fact(input logic [31:0] n);
        logic [31:0] r;
        r = 32'd1;
        for (int i = 2; i <= 12; i++) if (i <= n) r = r * i;
        return r;
    endfunction

    // Memory with 1-cycle read latency plus a stand-in core that stores n! at 198 on its first run cycle
    always @(posedge clk) begin
        if (mem_we) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
        rc <= cpu_run ? rc + 16'd1 : 16'd0;
        if (cpu_run && rc == 16'd0) mem[198] <= (halt_at != 16'd0) ? fact(mem[200]) : 32'd0;
    end

    // Activity counters sampled away from the active edge
    always @(negedge clk) begin
        if (busy) bcnt++;
        if (mem_we) wcnt++;
        if (cpu_run && mem_addr == 10'd200) rcnt++;
    end

    task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
        nvec++;
        if (a !== e) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_flags"}, {mem_we, cpu_run, busy, done, pass, timeout, fail_idx, cycles},
            {6'b0, 2'd2, 16'd0});
        chk({tag, "_bus"}, {mem_addr, mem_wdata, img_addr}, {10'd0, 32'd0, 10'd0});
    endtask

    task automatic run_vec(input vec_t v, input bit poke);
        int n;
        int nchk;
        int bad;
        halt_at = v.halt_at;
        chk_exp = {v.e1, v.e0};
        @(negedge clk);
        bcnt = 0; wcnt = 0; rcnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_rise", busy, 1);
        chk("clr_on_load", {done, pass, timeout, fail_idx, cycles}, {3'b000, 2'd2, 16'd0});
        if (poke) begin
            repeat (4) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        n = 0;
        while (done !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", done, 1);
        nchk = v.eto ? 0 : (v.efi == 2'd2 ? 2 : int'(v.efi) + 1);
        chk("pass", pass, v.ep);
        chk("timeout", timeout, v.eto);
        chk("fail_idx", fail_idx, v.efi);
        chk("cycles", cycles, v.ecyc);
        chk("idle_outs", {cpu_run, busy, mem_we}, 3'b000);
        chk("busy_cycles", bcnt, 18 + int'(v.ecyc) + 2 * nchk);
        chk("write_cycles", wcnt, 18);
        chk("chk1_reads", rcnt, (nchk == 2) ? 2 : 0);
        bad = 0;
        for (int i = 0; i < 16; i++) if (mem[i] !== img[i]) bad++;
        chk("image", bad, 0);
        chk("init_later_wins", mem[200], 7);
    endtask

    initial begin
        int n;
        nvec = 0; nmis = 0; bcnt = 0; wcnt = 0; rcnt = 0;
        rst_n = 1'b0; start = 1'b0; halt_at = 16'd0; chk_exp = '0;
        img = '{32'h280a00c8, 32'h28020001, 32'h0ce77800, 32'h21430000,
               32'h0ce77800, 32'h14431000, 32'h2c630001, 32'h0ce77800,
               32'h3460fffc, 32'h2542fffe, 32'hfc000000, 32'h0,
               32'h0, 32'h0, 32'h0, 32'h0};
        for (int i = 0; i < 1024; i++) mem[i] = 32'hdeadbeef;
        //          halt  e0     e1 pass to fi  cycles
        vt[0] = '{16'd20, 32'd5040, 32'd7, 1'b1, 1'b0, 2'd2, 16'd20};
        vt[1] = '{16'd20, 32'd5041, 32'd7, 1'b0, 1'b0, 2'd0, 16'd20};
        vt[2] = '{16'd0,  32'd5040, 32'd7, 1'b0, 1'b1, 2'd2, 16'd50};
        vt[3] = '{16'd50, 32'd5040, 32'd7, 1'b1, 1'b0, 2'd2, 16'd50};
        vt[4] = '{16'd1,  32'd5040, 32'd7, 1'b1, 1'b0, 2'd2, 16'd1};
        vt[5] = '{16'd20, 32'd5040, 32'd8, 1'b0, 1'b0, 2'd1, 16'd20};
        repeat (2) @(negedge clk);
        chk_reset("reset");
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) run_vec(vt[i], 1'b0);
        run_vec(vt[0], 1'b1);
        halt_at = 16'd20;
        chk_exp = {32'd7, 32'd5040};
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (cpu_run !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk("run_before_rst", cpu_run, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset("mid_run_reset");
        @(negedge clk);
        rst_n = 1'b1;
        run_vec(vt[0], 1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
